// File: rtl/tlp_tx_framer.sv
// tlp_tx_framer: drains TLP DWs from a show-ahead TX FIFO and frames them
// into sop/eop beats on a valid/ready link toward the data-link layer.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   fifo_data, fifo_empty       FIFO head DW (show-ahead) and empty flag
//   fifo_rd_en                  pop strobe, one DW per asserted cycle
//   ph_avail, pd_avail          posted header / data credits available
//   cr_consume, cr_data_used    admission pulse and data credits taken
//   tx_data, tx_valid           registered output beat
//   tx_sop, tx_eop              first / last DW of a TLP
//   tx_ready                    downstream accept
//   tlp_count                   completed-TLP counter (TLP_FRAMER_CNT_EN only)
//
// Optional feature: define TLP_FRAMER_CNT_EN to add the 16-bit tlp_count
// output, which counts accepted eop beats and wraps.

module tlp_tx_framer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [7:0]            ph_avail,
   input  logic [11:0]           pd_avail,
   output logic                  cr_consume,
   output logic [8:0]            cr_data_used,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  tx_sop,
   output logic                  tx_eop,
   input  logic                  tx_ready
`ifdef TLP_FRAMER_CNT_EN
   ,
   output logic [15:0]           tlp_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_PAYLOAD
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // remaining beats of the current TLP, header DWs left, payload flag
   logic [10:0] cnt;
   logic [10:0] cnt_nxt;
   logic [1:0]  hdr_left;
   logic [1:0]  hdr_left_nxt;
   logic        has_pl;
   logic        has_pl_nxt;

   logic        pop;
   logic        admit;
   logic        slot_free;
   logic        can_pop;

   // DW0 decode of the FIFO head, only meaningful in IDLE
   logic [1:0]  fmt;
   logic [10:0] len_n;
   logic [10:0] hdr_tot;
   logic [10:0] total;
   logic [8:0]  dcr_req;
   logic        credit_ok;

   assign fmt     = fifo_data[30:29];
   // a Length field of zero encodes the maximum of 1024 DWs
   assign len_n   = (fifo_data[9:0] == 10'd0) ? 11'd1024
                                              : {1'b0, fifo_data[9:0]};
   assign hdr_tot = fmt[0] ? 11'd4 : 11'd3;
   assign total   = hdr_tot + (fmt[1] ? len_n : 11'd0);
   // one data credit covers four DWs, rounded up; 1024 DWs -> 256
   assign dcr_req = fmt[1] ? 9'((len_n + 11'd3) >> 2) : 9'd0;

   assign credit_ok = (ph_avail != 8'd0) &&
                      (pd_avail >= {3'b000, dcr_req});

   assign slot_free = !tx_valid || tx_ready;
   assign can_pop   = slot_free && !fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      hdr_left_nxt = hdr_left;
      has_pl_nxt   = has_pl;
      pop          = 1'b0;
      admit        = 1'b0;
      unique case (state)
         S_IDLE: begin
            // credits are only looked at here; the whole TLP is then
            // committed regardless of later credit changes
            if (can_pop && credit_ok) begin
               pop          = 1'b1;
               admit        = 1'b1;
               cnt_nxt      = total - 11'd1;
               hdr_left_nxt = fmt[0] ? 2'd3 : 2'd2;
               has_pl_nxt   = fmt[1];
               state_nxt    = S_HDR;
            end
         end
         S_HDR: begin
            if (can_pop) begin
               pop          = 1'b1;
               cnt_nxt      = cnt - 11'd1;
               hdr_left_nxt = hdr_left - 2'd1;
               if (hdr_left == 2'd1) begin
                  state_nxt = has_pl ? S_PAYLOAD : S_IDLE;
               end
            end
         end
         S_PAYLOAD: begin
            if (can_pop) begin
               pop     = 1'b1;
               cnt_nxt = cnt - 11'd1;
               if (cnt == 11'd1) begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign fifo_rd_en = pop && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= 11'd0;
         hdr_left     <= 2'd0;
         has_pl       <= 1'b0;
         tx_data      <= '0;
         tx_valid     <= 1'b0;
         tx_sop       <= 1'b0;
         tx_eop       <= 1'b0;
         cr_consume   <= 1'b0;
         cr_data_used <= 9'd0;
      end else begin
         cnt          <= cnt_nxt;
         hdr_left     <= hdr_left_nxt;
         has_pl       <= has_pl_nxt;
         cr_consume   <= admit;
         cr_data_used <= admit ? dcr_req : 9'd0;
         if (pop) begin
            tx_data  <= fifo_data;
            tx_valid <= 1'b1;
            tx_sop   <= admit;
            // DW0 always leaves at least two beats, so sop and eop
            // can never land on the same beat
            tx_eop   <= (cnt_nxt == 11'd0);
         end else if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
         end
      end
   end

`ifdef TLP_FRAMER_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tlp_count <= 16'd0;
      end else if (tx_valid && tx_ready && tx_eop) begin
         tlp_count <= tlp_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tlp_tx_framer.sv
// tb_tlp_tx_framer: directed bench for tlp_tx_framer with a show-ahead
// FIFO model, an accepted-beat recorder and hand-computed expectations.

module tb_tlp_tx_framer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fifo_data;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [7:0]  ph_avail;
   logic [11:0] pd_avail;
   logic        cr_consume;
   logic [8:0]  cr_data_used;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_sop;
   logic        tx_eop;
   logic        tx_ready;
`ifdef TLP_FRAMER_CNT_EN
   logic [15:0] tlp_count;
`endif

   tlp_tx_framer dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_data    (fifo_data),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .ph_avail     (ph_avail),
      .pd_avail     (pd_avail),
      .cr_consume   (cr_consume),
      .cr_data_used (cr_data_used),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_sop       (tx_sop),
      .tx_eop       (tx_eop),
      .tx_ready     (tx_ready)
`ifdef TLP_FRAMER_CNT_EN
      ,
      .tlp_count    (tlp_count)
`endif
   );

   always #5 clk = ~clk;

   // show-ahead FIFO model
   logic [31:0] mem [0:4095];
   int          wr_ptr = 0;
   int          rd_ptr = 0;

   assign fifo_data  = mem[rd_ptr];
   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
   end

   // accepted-beat recorder, sampled on the falling edge
   logic [31:0] acc_data [0:4095];
   logic        acc_sop  [0:4095];
   logic        acc_eop  [0:4095];
   int          acc_cyc  [0:4095];
   int          acc_n = 0;
   logic [8:0]  cr_hist  [0:63];
   int          cr_n = 0;
   int          sop_err = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (tx_valid && tx_ready) begin
            acc_data[acc_n] <= tx_data;
            acc_sop[acc_n]  <= tx_sop;
            acc_eop[acc_n]  <= tx_eop;
            acc_cyc[acc_n]  <= cyc;
            acc_n           <= acc_n + 1;
         end
         if (cr_consume) begin
            cr_hist[cr_n] <= cr_data_used;
            cr_n          <= cr_n + 1;
            if (!tx_sop) sop_err <= sop_err + 1;
         end
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] dw);
      mem[wr_ptr] = dw;
      wr_ptr++;
   endtask

   task automatic wait_acc(input int target, input int budget,
                           input string tag);
      int k = 0;
      while (acc_n < target && k < budget) begin
         @(posedge clk);
         #2;
         k++;
      end
      check(tag, acc_n, target);
   endtask

   task automatic wait_exact(input int target, input int budget,
                             input string tag);
      int k = 0;
      while (acc_n != target && k < budget) begin
         @(posedge clk);
         #2;
         k++;
      end
      check(tag, acc_n, target);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b;
`ifdef TLP_FRAMER_CNT_EN
      logic [15:0] tc0;
`endif
      rst      = 1'b1;
      tx_ready = 1'b1;
      ph_avail = 8'd10;
      pd_avail = 12'd500;

      // 3DW MRd queued while in reset
      push(32'h0000_0001);
      push(32'hA000_0001);
      push(32'hA000_0002);
      @(negedge clk);
      @(negedge clk);
      check("rst_valid", tx_valid, 0);
      check("rst_sop", tx_sop, 0);
      check("rst_eop", tx_eop, 0);
      check("rst_data", tx_data, 0);
      check("rst_cr", cr_consume, 0);
      check("rst_cr_used", cr_data_used, 0);
      check("rst_rd_en", fifo_rd_en, 0);
      rst = 1'b0;

      // 3DW MRd: three back-to-back beats
      wait_acc(3, 20, "t1_done");
      check("t1_d0", acc_data[0], 32'h0000_0001);
      check("t1_d2", acc_data[2], 32'hA000_0002);
      check("t1_sop0", acc_sop[0], 1);
      check("t1_eop0", acc_eop[0], 0);
      check("t1_eop2", acc_eop[2], 1);
      check("t1_sop2", acc_sop[2], 0);
      check("t1_span", acc_cyc[2] - acc_cyc[0], 2);
      check("t1_cr_n", cr_n, 1);
      check("t1_cr_used", cr_hist[0], 0);

      // 4DW MWr len 2, then a 3DW MRd with no gap
      b = acc_n;
      push(32'h6000_0002);
      push(32'hC000_0001);
      push(32'hC000_0002);
      push(32'hC000_0003);
      push(32'hD000_0001);
      push(32'hD000_0002);
      push(32'h0000_0001);
      push(32'hE000_0001);
      push(32'hE000_0002);
      wait_acc(b + 9, 40, "t2_done");
      check("t2_eop5", acc_eop[b+5], 1);
      check("t2_eop4", acc_eop[b+4], 0);
      check("t2_d5", acc_data[b+5], 32'hD000_0002);
      check("t2_sop6", acc_sop[b+6], 1);
      check("t2_d6", acc_data[b+6], 32'h0000_0001);
      check("t2_gap", acc_cyc[b+6] - acc_cyc[b+5], 1);
      check("t2_eop8", acc_eop[b+8], 1);
      check("t2_cr_n", cr_n, 3);
      check("t2_cr_used0", cr_hist[1], 1);
      check("t2_cr_used1", cr_hist[2], 0);

      // backpressure on payload beat 2 of a 4DW MWr len 4
      b = acc_n;
      push(32'h6000_0004);
      push(32'hF000_0001);
      push(32'hF000_0002);
      push(32'hF000_0003);
      push(32'h9000_0001);
      push(32'h9000_0002);
      push(32'h9000_0003);
      push(32'h9000_0004);
      wait_exact(b + 5, 40, "t3_reach");
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_hold_data", tx_data, 32'h9000_0002);
         check("t3_hold_valid", tx_valid, 1);
         check("t3_hold_rd_en", fifo_rd_en, 0);
      end
      @(posedge clk);
      #2;
      tx_ready = 1'b1;
      wait_acc(b + 8, 40, "t3_done");
      check("t3_d0", acc_data[b], 32'h6000_0004);
      check("t3_d4", acc_data[b+4], 32'h9000_0001);
      check("t3_d5", acc_data[b+5], 32'h9000_0002);
      check("t3_d6", acc_data[b+6], 32'h9000_0003);
      check("t3_d7", acc_data[b+7], 32'h9000_0004);
      check("t3_eop7", acc_eop[b+7], 1);
      check("t3_cr_used", cr_hist[3], 1);

      // credit starvation: 3DW MWr len 8 with no data credits
      b = acc_n;
      pd_avail = 12'd0;
      push(32'h4000_0008);
      push(32'h1100_0001);
      push(32'h1100_0002);
      for (int i = 1; i <= 8; i++) push(32'h2200_0000 + i);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t4_no_pop", fifo_rd_en, 0);
         check("t4_no_valid", tx_valid, 0);
      end
      pd_avail = 12'd2;
      wait_acc(b + 11, 40, "t4_done");
      check("t4_cr_n", cr_n, 5);
      check("t4_cr_used", cr_hist[4], 2);
      check("t4_sop0", acc_sop[b], 1);
      check("t4_d0", acc_data[b], 32'h4000_0008);
      check("t4_d10", acc_data[b+10], 32'h2200_0008);
      check("t4_eop10", acc_eop[b+10], 1);

      // 3DW MWr with Length 0 -> 1024 payload DWs
      b = acc_n;
      pd_avail = 12'd300;
`ifdef TLP_FRAMER_CNT_EN
      tc0 = tlp_count;
`endif
      push(32'h4000_0000);
      push(32'h3300_0001);
      push(32'h3300_0002);
      for (int i = 0; i < 1024; i++) push(32'h5000_0000 + i);
      wait_acc(b + 1027, 1200, "t5_done");
      check("t5_sop0", acc_sop[b], 1);
      check("t5_eop1025", acc_eop[b+1025], 0);
      check("t5_eop1026", acc_eop[b+1026], 1);
      check("t5_dlast", acc_data[b+1026], 32'h5000_03FF);
      check("t5_span", acc_cyc[b+1026] - acc_cyc[b], 1026);
      check("t5_cr_used", cr_hist[5], 256);
`ifdef TLP_FRAMER_CNT_EN
      check("t5_tlp_count", tlp_count, tc0 + 16'd1);
`endif

      // reset at payload beat 5; FIFO head afterwards is a fresh DW0
      b = acc_n;
      push(32'h4000_0008);
      push(32'h6600_0001);
      push(32'h6600_0002);
      for (int i = 1; i <= 5; i++) push(32'h7700_0000 + i);
      push(32'h0000_0001);
      push(32'hB000_0007);
      push(32'hB000_0008);
      wait_exact(b + 7, 40, "t6_reach");
      check("t6_pre_data", tx_data, 32'h7700_0005);
      check("t6_pre_valid", tx_valid, 1);
      rst = 1'b1;
      #1;
      check("t6_rst_valid", tx_valid, 0);
      check("t6_rst_sop", tx_sop, 0);
      check("t6_rst_eop", tx_eop, 0);
      check("t6_rst_rd_en", fifo_rd_en, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_acc(b + 10, 40, "t6_done");
      check("t6_d0", acc_data[b+7], 32'h0000_0001);
      check("t6_sop0", acc_sop[b+7], 1);
      check("t6_d2", acc_data[b+9], 32'hB000_0008);
      check("t6_eop2", acc_eop[b+9], 1);
      check("t6_cr_n", cr_n, 8);
      check("t6_cr_used_abandon", cr_hist[6], 2);
      check("t6_cr_used_next", cr_hist[7], 0);
      repeat (5) @(negedge clk);
      check("t6_no_extra", acc_n, b + 10);

      check("cr_with_sop", sop_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
